// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// The optional randomised wait-state feature is enabled with DMEM_RAND_WAIT_EN.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          BYTE_LANES = 4;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    // One Fibonacci shift: new bit is the XOR of the tapped bits
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/wait_lfsr.sv
// 16-bit Fibonacci LFSR supplying extra wait states; advances once per enable.
// Only instantiated when DMEM_RAND_WAIT_EN is defined.
module wait_lfsr
    import dmem_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic [1:0] wait_bits_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next-state: step only on enable
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register, seeded on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Only the low two bits feed the wait counter
    assign wait_bits_o = lfsr_q[1:0];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the data-memory load/store interface: one request at a
// time, programmable wait states, byte-enabled word access on a local RAM,
// response held until the requester takes it.
// Optional feature: define DMEM_RAND_WAIT_EN to add 0..3 pseudo-random wait
// states per request (wait_lfsr sub-module).
module data_mem_responder
    import dmem_resp_pkg::*;
#(
    parameter int NUM_MEM_LOCS = 64,
    parameter int REG_WIDTH    = 32,
    parameter int LATENCY      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [BYTE_LANES-1:0] req_be,
    input  logic [REG_WIDTH-1:0]  req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [REG_WIDTH-1:0]  rsp_rdata,
    output logic                  rsp_err
);

    localparam int          AW        = $clog2(NUM_MEM_LOCS);
    // Wide enough for LATENCY (max 15) plus up to 3 random extra states
    localparam int          CW        = 5;
    localparam logic [31:0] MEM_BYTES = 32'(4 * NUM_MEM_LOCS);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          start_cnt_s;

    logic                   we_q;
    logic [31:0]            addr_q;
    logic [BYTE_LANES-1:0]  be_q;
    logic [REG_WIDTH-1:0]   wdata_q;

    logic [REG_WIDTH-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [REG_WIDTH-1:0]   mem_q [NUM_MEM_LOCS];

    logic                   accept_s;
    logic                   access_s;
    logic                   err_s;
    logic [AW-1:0]          idx_s;

    // Address checks on the captured request
    assign err_s = (addr_q[1:0] != 2'b00) || (addr_q >= MEM_BYTES);
    assign idx_s = addr_q[AW+1:2];

`ifdef DMEM_RAND_WAIT_EN
    logic [1:0] wait_bits_s;

    wait_lfsr u_wait_lfsr (
        .clk         (clk),
        .rst         (rst),
        .en_i        (accept_s),
        .wait_bits_o (wait_bits_s)
    );

    assign start_cnt_s = CW'(LATENCY) + {3'b000, wait_bits_s};
`else
    assign start_cnt_s = CW'(LATENCY);
`endif

    // FSM next state, wait counter and response data; the access happens on
    // the edge that leaves WAIT, so LATENCY==0 still spends one WAIT cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        accept_s = 1'b0;
        access_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    cnt_d    = start_cnt_s;
                    state_d  = WAIT;
                end else begin
                    state_d  = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == {CW{1'b0}}) begin
                    access_s = 1'b1;
                    state_d  = RESP;
                    err_d    = err_s;
                    if (!err_s && !we_q) begin
                        rdata_d = mem_q[idx_s];
                    end else begin
                        rdata_d = {REG_WIDTH{1'b0}};
                    end
                end else begin
                    cnt_d    = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            rdata_q <= {REG_WIDTH{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture the request only in the accepting cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= {BYTE_LANES{1'b0}};
            wdata_q <= {REG_WIDTH{1'b0}};
        end else if (accept_s) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            be_q    <= req_be;
            wdata_q <= req_wdata;
        end
    end

    // RAM: cleared by reset, lane-masked store on a valid access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_MEM_LOCS; i++) begin
                mem_q[i] <= {REG_WIDTH{1'b0}};
            end
        end else if (access_s && we_q && !err_s) begin
            for (int b = 0; b < BYTE_LANES; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_s][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Handshake flags follow the state register directly
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
